// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM single-port SRAM arbiter.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
package mem_arb_pkg;

    localparam int unsigned ADDR_W         = 14;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // SRAM command values meaning "no access"
    localparam logic              WEB_OFF  = 1'b1;
    localparam logic [DATA_W-1:0] BWEB_OFF = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        DM_RD = 2'd2
    } arb_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive cycles in which an IF request was denied and flags
// when that count reaches the configured starvation threshold.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_if_gnt,
    output logic o_starved
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_if_req || i_if_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_starved = (r_cnt == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one SRAM port.
// Define MEM_ARB_STATS_EN to add the stat_conflict / stat_if_starve counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_web,
    input  logic [DATA_W-1:0] dm_bweb,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              sram_web,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do,
    output logic              stall_if,
    output logic              stall_mem
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_conflict,
    output logic [31:0]       stat_if_starve
`endif
);

    logic              w_starved;
    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic [ADDR_W-1:0] r_a_hold;
    logic [DATA_W-1:0] r_di_hold;
    arb_state_t        r_state;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_if_req  (if_req),
        .i_if_gnt  (w_if_gnt),
        .o_starved (w_starved)
    );

    // DM has priority unless IF has been starved for STARVE_MAX cycles
    assign w_if_gnt = !rst && if_req && (!dm_req || w_starved);
    assign w_dm_gnt = !rst && dm_req && !w_if_gnt;

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign stall_if  = !rst && if_req && !w_if_gnt;
    assign stall_mem = !rst && dm_req && !w_dm_gnt;

    always_comb begin
        sram_web  = WEB_OFF;
        sram_bweb = BWEB_OFF;
        sram_a    = r_a_hold;
        sram_di   = r_di_hold;
        if (rst) begin
            sram_a  = '0;
            sram_di = '0;
        end else if (w_if_gnt) begin
            sram_a = if_addr;
        end else if (w_dm_gnt) begin
            sram_a   = dm_addr;
            sram_di  = dm_wdata;
            sram_web = dm_web;
            if (!dm_web) begin
                sram_bweb = dm_bweb;
            end
        end
    end

    // Address/data hold registers simply follow the driven command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_hold  <= '0;
            r_di_hold <= '0;
        end else begin
            r_a_hold  <= sram_a;
            r_di_hold <= sram_di;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_if_gnt) begin
            r_state <= IF_RD;
        end else if (w_dm_gnt && dm_web) begin
            r_state <= DM_RD;
        end else begin
            r_state <= IDLE;
        end
    end

    // rst gates the return path so a read granted just before reset is dropped
    assign if_rvalid = !rst && (r_state == IF_RD);
    assign dm_rvalid = !rst && (r_state == DM_RD);
    assign if_rdata  = if_rvalid ? sram_do : '0;
    assign dm_rdata  = dm_rvalid ? sram_do : '0;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_conflict;
    logic [31:0] r_stat_if_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_conflict  <= '0;
            r_stat_if_starve <= '0;
        end else begin
            if (if_req && dm_req) begin
                r_stat_conflict <= sat_inc32(r_stat_conflict);
            end
            if (w_if_gnt && dm_req) begin
                r_stat_if_starve <= sat_inc32(r_stat_if_starve);
            end
        end
    end

    assign stat_conflict  = r_stat_conflict;
    assign stat_if_starve = r_stat_if_starve;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural SRAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [13:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_web;
    logic [31:0] dm_bweb, dm_wdata;
    logic [13:0] dm_addr;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        sram_web;
    logic [31:0] sram_bweb, sram_di, sram_do;
    logic [13:0] sram_a;
    logic        stall_if, stall_mem;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_conflict, stat_if_starve;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [16384];

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_web    (dm_web),
        .dm_bweb   (dm_bweb),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .sram_web  (sram_web),
        .sram_bweb (sram_bweb),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_conflict  (stat_conflict),
        .stat_if_starve (stat_if_starve)
`endif
    );

    // Single-port SRAM: active-low write and bit mask, one-cycle read latency
    always @(posedge clk) begin
        if (rst) begin
            mem[14'h0000] <= 32'hA000_0000;
            mem[14'h0001] <= 32'hA000_0001;
            mem[14'h0002] <= 32'hA000_0002;
            mem[14'h0010] <= 32'hDEAD_BEEF;
            mem[14'h0020] <= 32'hCAFE_F00D;
            mem[14'h0030] <= 32'h3333_3333;
            mem[14'h0040] <= 32'hAAAA_AAAA;
        end else if (!sram_web) begin
            mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
        end
        if (sram_web) sram_do <= mem[sram_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
        chk({tag, ".dm_gnt"},    32'(dm_gnt),    32'd0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'd0);
        chk({tag, ".if_rdata"},  if_rdata,       32'd0);
        chk({tag, ".dm_rdata"},  dm_rdata,       32'd0);
        chk({tag, ".stall_if"},  32'(stall_if),  32'd0);
        chk({tag, ".stall_mem"}, 32'(stall_mem), 32'd0);
        chk({tag, ".sram_web"},  32'(sram_web),  32'd1);
        chk({tag, ".sram_bweb"}, sram_bweb,      32'hFFFF_FFFF);
        chk({tag, ".sram_a"},    32'(sram_a),    32'd0);
        chk({tag, ".sram_di"},   sram_di,        32'd0);
    endtask

    initial begin
        // Reset with both requests high: nothing may be granted or stalled
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_web = 1'b1;
        if_addr = 14'h0005; dm_addr = 14'h0006;
        dm_bweb = 32'hFFFF_FFFF; dm_wdata = 32'h5555_5555;
        next(); next();
        #2 chk_reset_outputs("rst");

        // Scenario 1: IF-only read
        next(); rst = 1'b0; if_req = 1'b1; if_addr = 14'h0010; dm_req = 1'b0;
        #2;
        chk("s1.if_gnt",   32'(if_gnt),   32'd1);
        chk("s1.sram_a",   32'(sram_a),   32'h0010);
        chk("s1.sram_web", 32'(sram_web), 32'd1);
        chk("s1.stall_if", 32'(stall_if), 32'd0);
        next(); if_req = 1'b0;
        #2;
        chk("s1.if_rvalid", 32'(if_rvalid), 32'd1);
        chk("s1.if_rdata",  if_rdata,       32'hDEAD_BEEF);
        chk("s1.dm_rvalid", 32'(dm_rvalid), 32'd0);

        // Scenario 2: contention, DM wins by default
        next(); if_req = 1'b1; if_addr = 14'h0030; dm_req = 1'b1; dm_web = 1'b1; dm_addr = 14'h0020;
        #2;
        chk("s2.dm_gnt",    32'(dm_gnt),    32'd1);
        chk("s2.if_gnt",    32'(if_gnt),    32'd0);
        chk("s2.stall_if",  32'(stall_if),  32'd1);
        chk("s2.stall_mem", 32'(stall_mem), 32'd0);
        chk("s2.sram_a",    32'(sram_a),    32'h0020);
        next(); if_req = 1'b0; dm_req = 1'b0;
        #2;
        chk("s2.dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("s2.dm_rdata",  dm_rdata,       32'hCAFE_F00D);
        chk("s2.if_rvalid", 32'(if_rvalid), 32'd0);
        chk("s2.if_rdata",  if_rdata,       32'd0);
        chk("s2.hold_a",    32'(sram_a),    32'h0020);

        // Scenario 3: continuous contention, IF forced in on the 5th cycle
        next(); if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("s3.dm_gnt%0d", i),   32'(dm_gnt),   32'd1);
            chk($sformatf("s3.stall_if%0d", i), 32'(stall_if), 32'd1);
            next();
        end
        #2;
        chk("s3.if_gnt",    32'(if_gnt),    32'd1);
        chk("s3.dm_gnt",    32'(dm_gnt),    32'd0);
        chk("s3.stall_mem", 32'(stall_mem), 32'd1);
        chk("s3.stall_if",  32'(stall_if),  32'd0);
        chk("s3.sram_a",    32'(sram_a),    32'h0030);
        chk("s3.dm_rdata",  dm_rdata,       32'hCAFE_F00D);
        next();
        #2;
        chk("s3.dm_regain", 32'(dm_gnt),    32'd1);
        chk("s3.if_rvalid", 32'(if_rvalid), 32'd1);
        chk("s3.if_rdata",  if_rdata,       32'h3333_3333);
        next(); if_req = 1'b0; dm_req = 1'b0;
        #2 chk("s3.dm_rvalid", 32'(dm_rvalid), 32'd1);

        // Scenario 3b: dropping if_req clears the starve count
        next(); if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("s3b.pre%0d", i), 32'(dm_gnt), 32'd1);
            next();
        end
        if_req = 1'b0;
        #2 chk("s3b.gap", 32'(dm_gnt), 32'd1);
        next(); if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 chk($sformatf("s3b.post%0d", i), 32'(dm_gnt), 32'd1);
            next();
        end
        #2 chk("s3b.if_gnt", 32'(if_gnt), 32'd1);
        next(); if_req = 1'b0; dm_req = 1'b0;

        // Scenario 4: masked DM write, then read back
        next(); dm_req = 1'b1; dm_web = 1'b0; dm_addr = 14'h0040;
        dm_wdata = 32'h1234_5678; dm_bweb = 32'hFFFF_0000;
        #2;
        chk("s4.dm_gnt",    32'(dm_gnt),    32'd1);
        chk("s4.sram_web",  32'(sram_web),  32'd0);
        chk("s4.sram_bweb", sram_bweb,      32'hFFFF_0000);
        chk("s4.sram_di",   sram_di,        32'h1234_5678);
        chk("s4.sram_a",    32'(sram_a),    32'h0040);
        next(); dm_web = 1'b1;
        #2;
        chk("s4.no_rvalid", 32'(dm_rvalid), 32'd0);
        chk("s4.rd_gnt",    32'(dm_gnt),    32'd1);
        chk("s4.rd_web",    32'(sram_web),  32'd1);
        chk("s4.rd_bweb",   sram_bweb,      32'hFFFF_FFFF);
        next(); dm_req = 1'b0;
        #2;
        chk("s4.dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("s4.dm_rdata",  dm_rdata,       32'hAAAA_5678);
        chk("s4.hold_di",   sram_di,        32'h1234_5678);
        chk("s4.hold_a",    32'(sram_a),    32'h0040);
        chk("s4.idle_web",  32'(sram_web),  32'd1);

        // Scenario 5: back-to-back IF reads
        next(); if_req = 1'b1; if_addr = 14'h0000;
        #2 chk("s5.gnt0", 32'(if_gnt), 32'd1);
        for (int i = 1; i < 3; i++) begin
            next(); if_addr = 14'(i);
            #2;
            chk($sformatf("s5.gnt%0d", i),    32'(if_gnt),    32'd1);
            chk($sformatf("s5.rvalid%0d", i), 32'(if_rvalid), 32'd1);
            chk($sformatf("s5.rdata%0d", i),  if_rdata,       32'hA000_0000 + 32'(i - 1));
        end
        next(); if_req = 1'b0;
        #2;
        chk("s5.rvalid3", 32'(if_rvalid), 32'd1);
        chk("s5.rdata3",  if_rdata,       32'hA000_0002);
        next();
        #2;
        chk("s5.rvalid_off", 32'(if_rvalid), 32'd0);
        chk("s5.rdata_off",  if_rdata,       32'd0);

        // Scenario 6: reset right after an IF grant suppresses rvalid
        next(); if_req = 1'b1; if_addr = 14'h0010;
        #2 chk("s6.if_gnt", 32'(if_gnt), 32'd1);
        next(); rst = 1'b1; if_req = 1'b0;
        #2 chk_reset_outputs("s6a");
        next();
        #2 chk_reset_outputs("s6b");
        next(); rst = 1'b0;
        #2;
        chk("s6.post_rvalid", 32'(if_rvalid), 32'd0);
        chk("s6.post_a",      32'(sram_a),    32'd0);
        chk("s6.post_di",     sram_di,        32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
